// File: rtl/bottle_pkg.sv
// Shared types and constants for the operator setting-entry stage.
package bottle_pkg;

  typedef enum logic [1:0] {S_IDLE, S_EDIT, S_CHECK, S_COMMIT} state_e;

  typedef logic [3:0] bcd_t;

  // Digit index under edit; doubles as the working-copy slot index.
  localparam logic [1:0] SEL_PILL_L = 2'd0;
  localparam logic [1:0] SEL_PILL_H = 2'd1;
  localparam logic [1:0] SEL_BOT_L  = 2'd2;
  localparam logic [1:0] SEL_BOT_H  = 2'd3;

  localparam logic [7:0] PILL_DEF_VAL = 8'h10;
  localparam logic [7:0] BOT_DEF_VAL  = 8'h05;

  // Bit positions of the four keys in the debouncer array.
  localparam int KEY_DEC  = 0;
  localparam int KEY_INC  = 1;
  localparam int KEY_SEL  = 2;
  localparam int KEY_OK   = 3;
  localparam int NUM_KEYS = 4;

  // Single BCD digit +1 with 9->0 wrap, no carry out.
  function automatic bcd_t bcd_inc(input bcd_t d);
    return (d >= 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  // Single BCD digit -1 with 0->9 wrap, no borrow out.
  function automatic bcd_t bcd_dec(input bcd_t d);
    return (d == 4'd0 || d > 4'd9) ? 4'd9 : d - 4'd1;
  endfunction

endpackage

// File: rtl/set_entry_key_debounce.sv
// One front-panel key: 2-flop synchroniser, run-length debouncer and a
// one-cycle press pulse on each debounced rising edge.
module key_debounce #(
  parameter int DEB_CYCLES = 20
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic level_o,
  output logic press_o
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic          lvl_q;
  logic          lvl_dly_q;
  logic          press_q;

  // Level flips only after DEB_CYCLES consecutive samples that disagree with it;
  // the press pulse is registered off the level, one cycle after it rises.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q    <= '0;
      cnt_q     <= '0;
      lvl_q     <= 1'b0;
      lvl_dly_q <= 1'b0;
      press_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw_i};
      if (sync_q[1] == lvl_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        cnt_q <= '0;
        lvl_q <= sync_q[1];
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
      lvl_dly_q <= lvl_q;
      press_q   <= lvl_q & ~lvl_dly_q;
    end
  end

  assign level_o = lvl_q;
  assign press_o = press_q;

endmodule

// File: rtl/set_entry.sv
// Setting-entry stage: edits a working copy of pills-per-bottle and
// bottles-per-batch (BCD) from four debounced keys, validates it and commits
// it atomically to the outputs consumed by the counting stage.
// Optional: define SET_ENTRY_AUTO_REPEAT_EN for inc/dec auto-repeat while held.
module set_entry
  import bottle_pkg::*;
#(
  parameter int         DEB_CYCLES    = 20,
  parameter logic [7:0] PILL_DEF      = PILL_DEF_VAL,
  parameter logic [7:0] BOT_DEF       = BOT_DEF_VAL,
  parameter int         REPEAT_CYCLES = 50
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN_set,
  input  logic       key_sel,
  input  logic       key_inc,
  input  logic       key_dec,
  input  logic       key_ok,
  output logic [3:0] maxL,
  output logic [3:0] maxH,
  output logic [3:0] bot_maxL,
  output logic [3:0] bot_maxH,
  output logic [1:0] sel,
  output logic       editing,
  output logic       valid,
  output logic       err
);

  logic [NUM_KEYS-1:0] key_raw;
  logic [NUM_KEYS-1:0] key_lvl;
  logic [NUM_KEYS-1:0] key_p;

  assign key_raw = {key_ok, key_sel, key_inc, key_dec};

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key [NUM_KEYS-1:0] (
    .clk_i   (CLK),
    .rst_i   (RST),
    .raw_i   (key_raw),
    .level_o (key_lvl),
    .press_o (key_p)
  );

  state_e          state_q;
  logic [3:0][3:0] wrk_q;      // [0]=pill L, [1]=pill H, [2]=bot L, [3]=bot H
  logic [7:0]      pill_q;
  logic [7:0]      bot_q;
  logic [1:0]      sel_q;
  logic            editing_q;
  logic            valid_q;
  logic            err_q;
  logic            en_q;

  logic ok_p, sel_p, inc_act, dec_act;

  assign ok_p  = key_p[KEY_OK];
  assign sel_p = key_p[KEY_SEL];

`ifdef SET_ENTRY_AUTO_REPEAT_EN
  // First repeat lands 4*REPEAT_CYCLES after the press action, later ones every
  // REPEAT_CYCLES; the timer starts when the level rises, one cycle before the press.
  localparam int RW        = $clog2(4 * REPEAT_CYCLES + 2);
  localparam int FIRST_THR = 4 * REPEAT_CYCLES + 1;
  localparam int NEXT_THR  = REPEAT_CYCLES - 1;

  logic [RW-1:0] rpt_cnt_q;
  logic          rpt_armed_q;
  logic          rpt_hold;
  logic          rpt_p;

  assign rpt_hold = (state_q == S_EDIT) && (key_lvl[KEY_INC] || key_lvl[KEY_DEC]);
  assign rpt_p    = rpt_hold &&
                    (rpt_armed_q ? (rpt_cnt_q == RW'(NEXT_THR)) : (rpt_cnt_q == RW'(FIRST_THR)));

  // Repeat timer; cleared on release or whenever the FSM leaves EDIT.
  always_ff @(posedge CLK) begin
    if (RST || !rpt_hold) begin
      rpt_cnt_q   <= '0;
      rpt_armed_q <= 1'b0;
    end else if (rpt_p) begin
      rpt_cnt_q   <= '0;
      rpt_armed_q <= 1'b1;
    end else begin
      rpt_cnt_q <= rpt_cnt_q + RW'(1);
    end
  end

  assign inc_act = key_p[KEY_INC] | (rpt_p & key_lvl[KEY_INC]);
  assign dec_act = key_p[KEY_DEC] | (rpt_p & key_lvl[KEY_DEC] & ~key_lvl[KEY_INC]);
`else
  localparam int unused_rpt_cycles = REPEAT_CYCLES;
  logic unused_key_lvl;
  assign unused_key_lvl = ^key_lvl;
  assign inc_act = key_p[KEY_INC];
  assign dec_act = key_p[KEY_DEC];
`endif

  // Edit/validate/commit FSM; outputs are registered and change only on commit or reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      pill_q    <= PILL_DEF;
      bot_q     <= BOT_DEF;
      wrk_q     <= {BOT_DEF, PILL_DEF};
      sel_q     <= SEL_PILL_L;
      editing_q <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      en_q      <= 1'b1;   // EN_set held through reset must toggle before editing starts
    end else begin
      en_q    <= EN_set;
      valid_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (EN_set && !en_q) begin
            wrk_q     <= {bot_q, pill_q};
            sel_q     <= SEL_PILL_L;
            err_q     <= 1'b0;
            editing_q <= 1'b1;
            state_q   <= S_EDIT;
          end
        end
        S_EDIT: begin
          if (!EN_set) begin
            editing_q <= 1'b0;
            state_q   <= S_IDLE;
          end else if (ok_p) begin
            state_q <= S_CHECK;
          end else if (sel_p) begin
            sel_q <= sel_q + 2'd1;
            err_q <= 1'b0;
          end else if (inc_act) begin
            wrk_q[sel_q] <= bcd_inc(wrk_q[sel_q]);
            err_q        <= 1'b0;
          end else if (dec_act) begin
            wrk_q[sel_q] <= bcd_dec(wrk_q[sel_q]);
            err_q        <= 1'b0;
          end
        end
        S_CHECK: begin
          // Downstream matches ones == maxL-1, so a zero ones digit can never fire.
          if (wrk_q[SEL_PILL_L] == 4'd0 ||
              {wrk_q[SEL_BOT_H], wrk_q[SEL_BOT_L]} == 8'h00) begin
            err_q   <= 1'b1;
            state_q <= S_EDIT;
          end else begin
            pill_q    <= {wrk_q[SEL_PILL_H], wrk_q[SEL_PILL_L]};
            bot_q     <= {wrk_q[SEL_BOT_H], wrk_q[SEL_BOT_L]};
            valid_q   <= 1'b1;
            err_q     <= 1'b0;
            editing_q <= 1'b0;
            state_q   <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign maxL     = pill_q[3:0];
  assign maxH     = pill_q[7:4];
  assign bot_maxL = bot_q[3:0];
  assign bot_maxH = bot_q[7:4];
  assign sel      = sel_q;
  assign editing  = editing_q;
  assign valid    = valid_q;
  assign err      = err_q;

endmodule
